// File: rtl/samm_pkg.sv
// -----------------------------------------------------------------------------
// samm_pkg
// Shared constants and types for the systolic-array result path.
//   N   : array dimension (rows = columns)
//   DW  : result element width
//   AW  : writeback address width
//   NE  : number of grid elements (N*N)
//   IW  : width of an element index
//   drain_state_t : result_drain stream FSM states
// -----------------------------------------------------------------------------
package samm_pkg;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int NE = N * N;
    localparam int IW = $clog2(NE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } drain_state_t;

endpackage

// File: rtl/drain_sel.sv
// -----------------------------------------------------------------------------
// drain_sel
// Generic NE:1 selector of DW-bit elements from a flat grid, indexed by idx.
// Element i sits at bits [i*DW +: DW]. Purely combinational.
// Ports:
//   grid : flat element bank (NE*DW bits)
//   idx  : element index
//   elem : selected element
// -----------------------------------------------------------------------------
module drain_sel #(
    parameter int NE = 64,
    parameter int DW = 16,
    parameter int IW = $clog2(NE)
) (
    input  logic [NE*DW-1:0] grid,
    input  logic [IW-1:0]    idx,
    output logic [DW-1:0]    elem
);

    assign elem = grid[idx*DW +: DW];

endmodule

// File: rtl/result_drain.sv
// -----------------------------------------------------------------------------
// result_drain
// Captures the N x N result grid on the rising edge of done_in, then streams
// it row-major over valid/ready with a write address, so the array can start
// the next multiply while the previous results drain.
//
// Ports:
//   clk        : system clock, all state on rising edge
//   rst        : asynchronous active-high reset
//   done_in    : level done from the array controller (rising edge = capture)
//   c_flat     : result grid, C(r,c) at [(r*N+c)*DW +: DW]
//   base_addr  : writeback start address, sampled at capture
//   out_valid  : stream element valid
//   out_ready  : downstream accepts element
//   out_data   : current element
//   out_addr   : write address of current element (wraps modulo 2^AW)
//   out_last   : marks the final element of the grid
//   busy       : high from capture until the drain completes
//   drain_done : one-cycle pulse after the final transfer
//   overrun    : sticky, a capture edge arrived while still draining
//   checksum   : (RESULT_CHECKSUM_EN only) running sum mod 2^DW of transfers
//
// Build option: define RESULT_CHECKSUM_EN to add the checksum output.
// -----------------------------------------------------------------------------
module result_drain
    import samm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             done_in,
    input  logic [NE*DW-1:0] c_flat,
    input  logic [AW-1:0]    base_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [AW-1:0]    out_addr,
    output logic             out_last,
    output logic             busy,
    output logic             drain_done,
`ifdef RESULT_CHECKSUM_EN
    output logic [DW-1:0]    checksum,
`endif
    output logic             overrun
);

    drain_state_t     state_r;
    logic             done_q_r;
    logic [NE*DW-1:0] snap_r;
    logic [IW-1:0]    idx_r;

    logic             capture_s;
    logic             xfer_s;
    logic [IW-1:0]    idx_nxt_s;
    logic [DW-1:0]    sel_data_s;

    assign capture_s = done_in & ~done_q_r;
    assign xfer_s    = out_valid & out_ready;
    assign idx_nxt_s = idx_r + IW'(1'b1);

    drain_sel #(
        .NE (NE),
        .DW (DW),
        .IW (IW)
    ) u_sel (
        .grid (snap_r),
        .idx  (idx_r),
        .elem (sel_data_s)
    );

    // Outside a stream the data bus reads zero rather than a stale element.
    assign out_data = out_valid ? sel_data_s : {DW{1'b0}};

    // Done-edge detector, snapshot bank, stream FSM and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            done_q_r   <= 1'b0;
            snap_r     <= {(NE*DW){1'b0}};
            idx_r      <= {IW{1'b0}};
            out_valid  <= 1'b0;
            out_addr   <= {AW{1'b0}};
            out_last   <= 1'b0;
            busy       <= 1'b0;
            drain_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done_q_r <= done_in;

            // A capture edge outside IDLE is dropped; the snapshot stays intact.
            if (capture_s && (state_r != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    if (capture_s) begin
                        snap_r    <= c_flat;
                        out_addr  <= base_addr;
                        idx_r     <= {IW{1'b0}};
                        out_valid <= 1'b1;
                        out_last  <= (NE == 1);
                        busy      <= 1'b1;
                        state_r   <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer_s) begin
                        idx_r    <= idx_nxt_s;
                        out_addr <= out_addr + AW'(1'b1);
                        if (out_last) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            drain_done <= 1'b1;
                            state_r    <= FINISH;
                        end else begin
                            out_last <= (idx_nxt_s == IW'(NE - 1));
                        end
                    end
                end
                FINISH: begin
                    drain_done <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    out_valid  <= 1'b0;
                    out_last   <= 1'b0;
                    drain_done <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

`ifdef RESULT_CHECKSUM_EN
    // Running sum of transferred elements, restarted by each accepted capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= {DW{1'b0}};
        end else if ((state_r == IDLE) && capture_s) begin
            checksum <= {DW{1'b0}};
        end else if (xfer_s) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Downstream of the systolic-array top: consumes the 8x8 grid of 16-bit accumulated results once the controller raises done.
- Snapshots the grid into a local register bank, then streams it row-major over a valid/ready interface with a write address for writeback to memory.
- Frees the array for the next multiply while results drain.

Parameters:
N, 8, array dimension (rows = columns)
DW, 16, result element width
AW, 10, writeback address width

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  reset, asynchronous, active-high
done_in  input  1  level done from array controller; rising edge triggers capture
c_flat  input  N*N*DW  results; C(r,c) at bits [(r*N+c)*DW +: DW]
base_addr  input  AW  writeback start address; sampled at capture
out_valid  output  1  stream element valid
out_ready  input  1  downstream accepts element
out_data  output  DW  current element
out_addr  output  AW  write address of current element
out_last  output  1  high with element index N*N-1
busy  output  1  high from capture until drain complete
drain_done  output  1  one-cycle pulse after final transfer
overrun  output  1  sticky: new done edge arrived while busy

Behaviour:
- Reset: state IDLE; all outputs 0; idx = 0; done_q = 0; snapshot bank = 0; overrun cleared.
- Edge detect: done_q registers done_in; capture event = done_in & ~done_q.
- States: IDLE, STREAM, FINISH.
- IDLE + capture event: load all N*N elements of c_flat and base_addr into registers at that edge. Next state STREAM, idx = 0, busy = 1.
- Capture latency: out_valid first high on the cycle after the capture edge.
- STREAM:
  - out_valid = 1.
  - out_data = snapshot[idx], combinational select from registered bank.
  - out_addr = latched base + idx, modulo 2^AW; address wraps with no error.
  - out_last = (idx == N*N-1).
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - On transfer, idx increments.
  - When out_valid is high and out_ready is low, out_data, out_addr and out_last hold stable.
  - out_valid never drops without a transfer.
- Transfer with out_last: next state FINISH; out_valid = 0.
- FINISH: drain_done = 1 for exactly one cycle; busy = 0 from the next cycle; next state IDLE.
- Throughput: 1 element/cycle with out_ready held high, so 64 transfer cycles.
- Capture event in STREAM or FINISH:
  - Ignored; snapshot is not disturbed.
  - overrun sets and stays set until rst.
- done_in held high continuously: no re-capture, because edge detection is used.
- c_flat changing after capture has no effect.
- rst asserted mid-stream: immediate return to IDLE, outputs 0; no drain_done pulse.

Optional Feature:
- Macro: RESULT_CHECKSUM_EN.
- Defined:
  - Adds output checksum [DW-1:0].
  - Running sum, modulo 2^DW, of every transferred out_data. Cleared at capture.
  - Final value valid and held from the drain_done cycle until the next capture.
  - Reset value 0.
- Undefined: port and adder are absent; all other behaviour is identical.

Decomposition:
- Shared package samm_pkg:
  - Constants N, DW, AW.
  - Element count N*N.
  - State enum {IDLE, STREAM, FINISH}.
- One sub-module, drain_sel: an N*N:1 DW-bit combinational selector indexed by idx, reusable for other grid readouts.
- FSM, snapshot bank and counters stay in result_drain.

Test Plan:
1. Load C(r,c) = r*16+c, base_addr = 0x100, pulse done_in, out_ready = 1.
   -> out_valid rises one cycle after the capture edge.
   -> 64 transfers: data 0x00,0x01,...,0x77; addresses 0x100..0x13F.
   -> out_last only on the 64th transfer; drain_done pulses on the next cycle.
2. Backpressure: toggle out_ready 1,0,0,1 repeatedly.
   -> data and address stable while stalled; no element lost or duplicated; sequence identical to test 1.
3. base_addr = 0x3F0.
   -> addresses 0x3F0..0x3FF, then 0x000..0x02F (wrap).
4. Second done edge at element 10; c_flat changed after capture.
   -> overrun = 1; stream continues with original snapshot values; single drain_done.
5. rst asserted at element 30.
   -> out_valid = 0 and busy = 0 immediately; no drain_done.
   -> a new done edge restarts from element 0.
6. RESULT_CHECKSUM_EN defined, all C = 0x1000.
   -> checksum = 0x0000 (64 x 0x1000 mod 2^16) at drain_done.
   -> with C(r,c) = 1, checksum = 0x0040.
